dpc_ins_seq: RTL and testbench
==============================

Name: dpc_ins_seq

Overview:
Frame-synchronous sequencer and configurator for the DPC defect-insertion stage.
- Holds a small programmable table of insertion configurations: mode, replacement value, horizontal step, vertical step.
- Steps through the table, applying each entry for a programmable number of frames.
- Drives the insertion stage's r_mode_sel/r_clr_chg/r_hstep/r_vstep/r_ins_en through shadow registers that only change at frame start, so a frame is never corrupted mid-stream.

Parameters:
RAW_CIIW, 10, raw pixel bit width (replacement value width)
STEP_WTH, 8, width of hstep/vstep
NUM_ENTRY, 8, configuration table depth
ENT_AW, $clog2(NUM_ENTRY), table address width
FRM_CNT_WTH, 8, frames-per-entry counter width
ENT_WD, 1+RAW_CIIW+2*STEP_WTH, packed entry width {mode, clr_chg, hstep, vstep}

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_vstr  in  1  frame-start pulse, one cycle, at least 1 cycle before first i_hstr of the frame
i_hstr  in  1  line-start pulse (statistics only)
r_tbl_wr  in  1  table write strobe
r_tbl_addr  in  ENT_AW  table write address
r_tbl_wdata  in  ENT_WD  packed entry {mode[MSB], clr_chg, hstep, vstep[LSBs]}
r_num_entry  in  ENT_AW+1  number of active entries (1..NUM_ENTRY)
r_frm_per_entry  in  FRM_CNT_WTH  frames per entry; 0 treated as 1
r_seq_loop  in  1  1: wrap to entry 0 after last entry
r_seq_start  in  1  start pulse
r_seq_stop  in  1  stop request pulse
o_mode_sel  out  1  shadow mode to insertion stage
o_clr_chg  out  RAW_CIIW  shadow replacement value
o_hstep  out  STEP_WTH  shadow horizontal step
o_vstep  out  STEP_WTH  shadow vertical step
o_ins_en  out  1  shadow insertion enable
o_cfg_upd  out  1  one-cycle pulse when shadow outputs changed
o_entry_idx  out  ENT_AW  index of entry currently applied
o_seq_busy  out  1  high in ARM/RUN
o_seq_done  out  1  one-cycle pulse on sequence end
o_ent_skip  out  1  sticky: an entry with hstep==0 or vstep==0 was skipped; cleared on r_seq_start

Behaviour:
Reset:
- All outputs 0; FSM in IDLE.
- Table contents reset to 0.
- Internal stop-pending and frame counter cleared.

Table:
- Write on r_tbl_wr, any state.
- A write to an entry takes effect the next time that entry is loaded; the active shadow is not touched.

Entry loading (at a frame boundary):
- Shadow registers are written on the clock after i_vstr is sampled high; o_cfg_upd pulses in that same cycle.
- Entry valid only if hstep!=0 and vstep!=0.
- Invalid entry: o_ins_en=0 for that entry's frames, o_ent_skip set, frame counting proceeds normally.

FSM:
- IDLE: r_seq_start with r_num_entry!=0 and no r_seq_stop in the same cycle -> ARM. Clears o_ent_skip, entry index 0, frame counter 0. Start with r_num_entry==0 is ignored.
- ARM: i_vstr -> load entry 0, frame counter 0, go to RUN. r_seq_stop -> IDLE with o_seq_done pulse and no shadow update.
- RUN:
  - r_seq_stop sets stop-pending; no immediate effect, so the current frame completes.
  - On i_vstr with stop-pending: o_ins_en=0, o_cfg_upd pulse -> DONE.
  - On i_vstr otherwise, if frame counter < max(r_frm_per_entry,1)-1: increment the counter; no shadow change.
  - Else if index < r_num_entry-1: load index+1, counter 0.
  - Else if r_seq_loop: load entry 0.
  - Else: o_ins_en=0, o_cfg_upd pulse -> DONE.
- DONE: o_seq_done=1 for one cycle -> IDLE. Shadow values other than o_ins_en are held.

Simultaneous events and boundary conditions:
- r_seq_start outside IDLE is ignored.
- r_seq_stop and i_vstr in the same cycle in RUN: stop becomes pending, and that i_vstr is processed as a normal boundary. The stop applies at the next i_vstr.
- r_num_entry > NUM_ENTRY saturates to NUM_ENTRY.
- The frame counter never wraps; it is compared and cleared as above.
- Asynchronous reset mid-sequence returns immediately to the reset state, with o_ins_en=0.

Optional Feature:
DPC_INS_SEQ_STAT_EN
- Defined: adds output o_frm_lines [15:0], the number of i_hstr pulses counted between consecutive i_vstr pulses. It is latched at each i_vstr and the internal counter restarts. The counter saturates at 16'hFFFF. It is used to check that vstep-based insertion density matches frame height.
- Not defined: no port, no counter logic.

Decomposition:
- Shared package dpc_pkg:
  - entry field offsets/widths (ENT_WD, field LSB positions)
  - FSM state encoding (IDLE=2'd0, ARM=2'd1, RUN=2'd2, DONE=2'd3)
  - STEP_WTH/RAW_CIIW defaults
- One natural sub-module, dpc_ins_tbl: NUM_ENTRY x ENT_WD register file with one write port and one combinational read port. The sequencer top holds the FSM, counters and shadow registers.

Test Plan:
- Reset then idle: drive 3 i_vstr, no start -> all outputs 0, o_cfg_upd never pulses.
- Table {e0: mode0, clr 10'h3FF, h4, v4; e1: mode1, clr 10'h000, h8, v2}, r_num_entry=2, r_frm_per_entry=2, loop=0, start, 5 vstr:
  - vstr1: e0 applied, o_ins_en=1.
  - vstr3: e1 applied, o_entry_idx=1.
  - vstr5: o_ins_en=0, o_seq_done pulse.
- Same table, loop=1, r_frm_per_entry=0, 4 vstr -> entries apply as 0, 1, 0, 1, one per frame, with o_cfg_upd on each.
- Stop mid-frame: in RUN pulse r_seq_stop between vstrs -> outputs unchanged until next vstr, then o_ins_en=0, then o_seq_done.
- Entry with hstep=0 -> o_ins_en=0 for its frames, o_ent_skip=1, sequence continues to next entry. Next r_seq_start clears o_ent_skip.
- Assert rst_n low during RUN with o_ins_en=1 -> o_ins_en=0 asynchronously, FSM IDLE; r_seq_start after release restarts from entry 0.

Source files
------------

// File: rtl/dpc_pkg.sv
// Shared definitions for the DPC defect-insertion sequencer: entry layout, FSM encoding, defaults.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package dpc_pkg;

   localparam int RAW_CIIW_DEF  = 10;
   localparam int STEP_WTH_DEF  = 8;
   localparam int NUM_ENTRY_DEF = 8;
   localparam int FRM_CNT_DEF   = 8;

   // Packed entry layout, LSB first: vstep, hstep, clr_chg, mode
   function automatic int ent_wd(input int raw_w, input int step_w);
      return 1 + raw_w + 2 * step_w;
   endfunction

   function automatic int vstep_lsb();
      return 0;
   endfunction

   function automatic int hstep_lsb(input int step_w);
      return step_w;
   endfunction

   function automatic int clr_lsb(input int step_w);
      return 2 * step_w;
   endfunction

   function automatic int mode_bit(input int raw_w, input int step_w);
      return raw_w + 2 * step_w;
   endfunction

   localparam int ENT_WD_DEF = 1 + RAW_CIIW_DEF + 2 * STEP_WTH_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/dpc_ins_tbl.sv
// Configuration table: NUM_ENTRY x ENT_WD register file, one write port, one combinational read port.
// Latency: write visible on the cycle after the strobe; read is combinational.
// Backpressure: none; writes are always accepted, out-of-range addresses are dropped / read as zero.
module dpc_ins_tbl #(
   parameter int NUM_ENTRY = 8,
   parameter int ENT_WD    = 27,
   parameter int ENT_AW    = $clog2(NUM_ENTRY)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [ENT_AW-1:0] wr_addr,
   input  logic [ENT_WD-1:0] wr_data,
   input  logic [ENT_AW-1:0] rd_addr,
   output logic [ENT_WD-1:0] rd_data
);

   localparam logic [ENT_AW:0] DEPTH = (ENT_AW + 1)'(NUM_ENTRY);

   logic [ENT_WD-1:0] mem [NUM_ENTRY];

   // Table storage: cleared on reset, written on strobe in any sequencer state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRY; i++) begin
            mem[i] <= '0;
         end
      end else if (wr && ({1'b0, wr_addr} < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Combinational read, guarded for non-power-of-two depths
   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_addr} < DEPTH) begin
         rd_data = mem[rd_addr];
      end
   end

endmodule

// File: rtl/dpc_ins_seq.sv
// Frame-synchronous sequencer: steps a config table, updating insertion shadows only at frame start.
// Latency: shadows and o_cfg_upd update on the clock edge that samples i_vstr high.
// Backpressure: none; i_vstr is never stalled. Optional DPC_INS_SEQ_STAT_EN adds o_frm_lines.
module dpc_ins_seq
   import dpc_pkg::*;
#(
   parameter int RAW_CIIW    = RAW_CIIW_DEF,
   parameter int STEP_WTH    = STEP_WTH_DEF,
   parameter int NUM_ENTRY   = NUM_ENTRY_DEF,
   parameter int ENT_AW      = $clog2(NUM_ENTRY),
   parameter int FRM_CNT_WTH = FRM_CNT_DEF,
   parameter int ENT_WD      = 1 + RAW_CIIW + 2 * STEP_WTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_vstr,
   input  logic                   i_hstr,
   input  logic                   r_tbl_wr,
   input  logic [ENT_AW-1:0]      r_tbl_addr,
   input  logic [ENT_WD-1:0]      r_tbl_wdata,
   input  logic [ENT_AW:0]        r_num_entry,
   input  logic [FRM_CNT_WTH-1:0] r_frm_per_entry,
   input  logic                   r_seq_loop,
   input  logic                   r_seq_start,
   input  logic                   r_seq_stop,
   output logic                   o_mode_sel,
   output logic [RAW_CIIW-1:0]    o_clr_chg,
   output logic [STEP_WTH-1:0]    o_hstep,
   output logic [STEP_WTH-1:0]    o_vstep,
   output logic                   o_ins_en,
   output logic                   o_cfg_upd,
   output logic [ENT_AW-1:0]      o_entry_idx,
   output logic                   o_seq_busy,
   output logic                   o_seq_done,
   output logic                   o_ent_skip
`ifdef DPC_INS_SEQ_STAT_EN
   ,
   output logic [15:0]            o_frm_lines
`endif
);

   localparam int VSTEP_LSB = vstep_lsb();
   localparam int HSTEP_LSB = hstep_lsb(STEP_WTH);
   localparam int CLR_LSB   = clr_lsb(STEP_WTH);
   localparam int MODE_BIT  = mode_bit(RAW_CIIW, STEP_WTH);
   localparam logic [ENT_AW:0] NUM_MAX = (ENT_AW + 1)'(NUM_ENTRY);

   seq_state_t             state;
   logic                   stop_pend;
   logic [FRM_CNT_WTH-1:0] frm_cnt;

   logic [ENT_AW:0]        num_eff;
   logic [ENT_AW:0]        num_last;
   logic [FRM_CNT_WTH-1:0] frm_max;
   logic [ENT_AW-1:0]      ld_idx;
   logic [ENT_WD-1:0]      ent_dat;
   logic                   ent_mode;
   logic [RAW_CIIW-1:0]    ent_clr;
   logic [STEP_WTH-1:0]    ent_h;
   logic [STEP_WTH-1:0]    ent_v;
   logic                   ent_vld;
   logic                   has_next;
   logic                   load_ent;
   logic                   end_seq;
   logic                   cnt_inc;

   dpc_ins_tbl #(
      .NUM_ENTRY (NUM_ENTRY),
      .ENT_WD    (ENT_WD),
      .ENT_AW    (ENT_AW)
   ) u_tbl (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (r_tbl_wr),
      .wr_addr (r_tbl_addr),
      .wr_data (r_tbl_wdata),
      .rd_addr (ld_idx),
      .rd_data (ent_dat)
   );

   assign ent_mode = ent_dat[MODE_BIT];
   assign ent_clr  = ent_dat[CLR_LSB +: RAW_CIIW];
   assign ent_h    = ent_dat[HSTEP_LSB +: STEP_WTH];
   assign ent_v    = ent_dat[VSTEP_LSB +: STEP_WTH];
   assign ent_vld  = (ent_h != '0) && (ent_v != '0);

   // Effective table size and per-entry frame limit (count saturates, zero frames means one)
   always_comb begin
      num_eff  = (r_num_entry > NUM_MAX) ? NUM_MAX : r_num_entry;
      num_last = (num_eff == '0) ? '0 : num_eff - 1'b1;
      frm_max  = (r_frm_per_entry == '0) ? '0 : r_frm_per_entry - 1'b1;
      has_next = ({1'b0, o_entry_idx} < num_last);
   end

   // Frame-boundary decision: which entry to fetch and whether to load, count or finish
   always_comb begin
      ld_idx   = '0;
      load_ent = 1'b0;
      end_seq  = 1'b0;
      cnt_inc  = 1'b0;
      if (state == ST_RUN && has_next) begin
         ld_idx = o_entry_idx + 1'b1;
      end
      case (state)
         ST_ARM: begin
            load_ent = i_vstr && !r_seq_stop;
         end
         ST_RUN: begin
            if (i_vstr) begin
               if (stop_pend) begin
                  end_seq = 1'b1;
               end else if (frm_cnt < frm_max) begin
                  cnt_inc = 1'b1;
               end else if (has_next || r_seq_loop) begin
                  load_ent = 1'b1;
               end else begin
                  end_seq = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Sequencer FSM with registered shadow, status and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         stop_pend   <= 1'b0;
         frm_cnt     <= '0;
         o_mode_sel  <= 1'b0;
         o_clr_chg   <= '0;
         o_hstep     <= '0;
         o_vstep     <= '0;
         o_ins_en    <= 1'b0;
         o_cfg_upd   <= 1'b0;
         o_entry_idx <= '0;
         o_seq_busy  <= 1'b0;
         o_seq_done  <= 1'b0;
         o_ent_skip  <= 1'b0;
      end else begin
         o_cfg_upd  <= 1'b0;
         o_seq_done <= 1'b0;

         if (load_ent) begin
            o_mode_sel  <= ent_mode;
            o_clr_chg   <= ent_clr;
            o_hstep     <= ent_h;
            o_vstep     <= ent_v;
            o_ins_en    <= ent_vld;
            o_entry_idx <= ld_idx;
            o_cfg_upd   <= 1'b1;
            frm_cnt     <= '0;
            if (!ent_vld) begin
               o_ent_skip <= 1'b1;
            end
         end

         if (cnt_inc) begin
            frm_cnt <= frm_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (r_seq_start && (num_eff != '0) && !r_seq_stop) begin
                  state       <= ST_ARM;
                  o_seq_busy  <= 1'b1;
                  o_ent_skip  <= 1'b0;
                  o_entry_idx <= '0;
                  frm_cnt     <= '0;
                  stop_pend   <= 1'b0;
               end
            end
            ST_ARM: begin
               if (r_seq_stop) begin
                  state      <= ST_IDLE;
                  o_seq_busy <= 1'b0;
                  o_seq_done <= 1'b1;
               end else if (i_vstr) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (end_seq) begin
                  o_ins_en   <= 1'b0;
                  o_cfg_upd  <= 1'b1;
                  o_seq_busy <= 1'b0;
                  o_seq_done <= 1'b1;
                  stop_pend  <= 1'b0;
                  state      <= ST_DONE;
               end else if (r_seq_stop) begin
                  stop_pend <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DPC_INS_SEQ_STAT_EN
   logic [15:0] line_cnt;

   // Lines-per-frame statistic: latched at each frame start, counter restarts and saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_cnt    <= '0;
         o_frm_lines <= '0;
      end else if (i_vstr) begin
         o_frm_lines <= line_cnt;
         line_cnt    <= i_hstr ? 16'd1 : 16'd0;
      end else if (i_hstr && line_cnt != 16'hFFFF) begin
         line_cnt <= line_cnt + 16'd1;
      end
   end
`else
   logic unused_hstr;
   assign unused_hstr = i_hstr;
`endif

endmodule

// File: tb/tb_dpc_ins_seq.sv
// Bench for dpc_ins_seq: scoreboard of expected shadow updates, popped on every o_cfg_upd.
// Latency: checks outputs at the falling edge after the edge that sampled each stimulus.
// Backpressure: not applicable.
module tb_dpc_ins_seq;

   localparam int RAW = 10;
   localparam int STW = 8;
   localparam int NE  = 8;
   localparam int AW  = 3;
   localparam int FCW = 8;
   localparam int EW  = 1 + RAW + 2 * STW;

   typedef struct packed {
      logic           mode;
      logic [RAW-1:0] clr;
      logic [STW-1:0] h;
      logic [STW-1:0] v;
      logic           en;
      logic [AW-1:0]  idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic i_vstr, i_hstr, r_tbl_wr, r_seq_loop, r_seq_start, r_seq_stop;
   logic [AW-1:0]  r_tbl_addr;
   logic [EW-1:0]  r_tbl_wdata;
   logic [AW:0]    r_num_entry;
   logic [FCW-1:0] r_frm_per_entry;
   logic           o_mode_sel, o_ins_en, o_cfg_upd, o_seq_busy, o_seq_done, o_ent_skip;
   logic [RAW-1:0] o_clr_chg;
   logic [STW-1:0] o_hstep, o_vstep;
   logic [AW-1:0]  o_entry_idx;
`ifdef DPC_INS_SEQ_STAT_EN
   logic [15:0]    o_frm_lines;
`endif

   exp_t          sb[$];
   logic [EW-1:0] tbl_m [NE];
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   dpc_ins_seq u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_vstr          (i_vstr),
      .i_hstr          (i_hstr),
      .r_tbl_wr        (r_tbl_wr),
      .r_tbl_addr      (r_tbl_addr),
      .r_tbl_wdata     (r_tbl_wdata),
      .r_num_entry     (r_num_entry),
      .r_frm_per_entry (r_frm_per_entry),
      .r_seq_loop      (r_seq_loop),
      .r_seq_start     (r_seq_start),
      .r_seq_stop      (r_seq_stop),
      .o_mode_sel      (o_mode_sel),
      .o_clr_chg       (o_clr_chg),
      .o_hstep         (o_hstep),
      .o_vstep         (o_vstep),
      .o_ins_en        (o_ins_en),
      .o_cfg_upd       (o_cfg_upd),
      .o_entry_idx     (o_entry_idx),
      .o_seq_busy      (o_seq_busy),
      .o_seq_done      (o_seq_done),
      .o_ent_skip      (o_ent_skip)
`ifdef DPC_INS_SEQ_STAT_EN
      ,
      .o_frm_lines     (o_frm_lines)
`endif
   );

   // Advance to the next falling edge and pop the scoreboard on any shadow update
   task automatic step();
      exp_t e;
      exp_t got;
      @(negedge clk);
      if (o_cfg_upd === 1'b1) begin
         vectors++;
         got = '{o_mode_sel, o_clr_chg, o_hstep, o_vstep, o_ins_en, o_entry_idx};
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL cfg_upd_unexpected got=%h expected no update", got);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               miscompares++;
               $display("FAIL cfg_upd_shadow got=%h expected=%h", got, e);
            end
         end
      end
   endtask

   task automatic push_exp(input int idx, input logic en);
      exp_t e;
      e.mode = tbl_m[idx][EW-1];
      e.clr  = tbl_m[idx][2*STW +: RAW];
      e.h    = tbl_m[idx][STW +: STW];
      e.v    = tbl_m[idx][0 +: STW];
      e.en   = en;
      e.idx  = AW'(idx);
      sb.push_back(e);
   endtask

   task automatic wr_tbl(input int addr, input logic [EW-1:0] d);
      r_tbl_wr    = 1'b1;
      r_tbl_addr  = AW'(addr);
      r_tbl_wdata = d;
      tbl_m[addr] = d;
      step();
      r_tbl_wr    = 1'b0;
   endtask

   task automatic pulse_vstr(input logic with_stop);
      i_vstr     = 1'b1;
      r_seq_stop = with_stop;
      step();
      i_vstr     = 1'b0;
      r_seq_stop = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         i_hstr = i[0];
         step();
      end
      i_hstr = 1'b0;
   endtask

   task automatic seq_start();
      r_seq_start = 1'b1;
      step();
      r_seq_start = 1'b0;
   endtask

   task automatic chk_sb_empty(input string name);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL %s_sb_left got=%0d pending expected=0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      vectors++;
      if ({o_mode_sel, o_clr_chg, o_hstep, o_vstep, o_ins_en, o_cfg_upd, o_entry_idx,
           o_seq_busy, o_seq_done, o_ent_skip} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got nonzero busy=%b en=%b expected all 0", o_seq_busy, o_ins_en);
      end
      for (int k = 0; k < 3; k++) begin
         pulse_vstr(1'b0);
         idle(3);
      end
      vectors++;
      if ({o_ins_en, o_seq_busy, o_hstep, o_entry_idx} !== '0) begin
         miscompares++;
         $display("FAIL idle_vstr got en=%b busy=%b h=%h expected 0", o_ins_en, o_seq_busy, o_hstep);
      end
   endtask

   task automatic test_seq_once();
      wr_tbl(0, {1'b0, 10'h3FF, 8'd4, 8'd4});
      wr_tbl(1, {1'b1, 10'h000, 8'd8, 8'd2});
      r_num_entry = 4'd2; r_frm_per_entry = 8'd2; r_seq_loop = 1'b0;
      seq_start();
      vectors++;
      if ({o_seq_busy, o_ins_en} !== 2'b10) begin
         miscompares++;
         $display("FAIL once_arm got busy=%b en=%b expected busy=1 en=0", o_seq_busy, o_ins_en);
      end
      push_exp(0, 1'b1); pulse_vstr(1'b0);
      vectors++;
      if ({o_ins_en, o_entry_idx} !== {1'b1, 3'd0}) begin
         miscompares++;
         $display("FAIL once_vstr1 got en=%b idx=%0d expected en=1 idx=0", o_ins_en, o_entry_idx);
      end
      idle(4); pulse_vstr(1'b0); idle(4);
      push_exp(1, 1'b1); pulse_vstr(1'b0);
      vectors++;
      if ({o_ins_en, o_entry_idx, o_mode_sel} !== {1'b1, 3'd1, 1'b1}) begin
         miscompares++;
         $display("FAIL once_vstr3 got en=%b idx=%0d mode=%b expected 1/1/1", o_ins_en, o_entry_idx, o_mode_sel);
      end
      idle(4); pulse_vstr(1'b0); idle(4);
      push_exp(1, 1'b0); pulse_vstr(1'b0);
      vectors++;
      if ({o_seq_done, o_ins_en, o_seq_busy} !== 3'b100) begin
         miscompares++;
         $display("FAIL once_vstr5 got done=%b en=%b busy=%b expected 1/0/0", o_seq_done, o_ins_en, o_seq_busy);
      end
      step();
      vectors++;
      if (o_seq_done !== 1'b0) begin
         miscompares++;
         $display("FAIL once_done_pulse got=%b expected=0", o_seq_done);
      end
      chk_sb_empty("once");
   endtask

   task automatic test_loop();
      r_frm_per_entry = 8'd0; r_seq_loop = 1'b1;
      seq_start();
      for (int k = 0; k < 4; k++) begin
         push_exp(k % 2, 1'b1);
         pulse_vstr(k == 3);
         vectors++;
         if (o_entry_idx !== AW'(k % 2)) begin
            miscompares++;
            $display("FAIL loop_idx%0d got=%0d expected=%0d", k, o_entry_idx, k % 2);
         end
         idle(3);
      end
      push_exp(1, 1'b0); pulse_vstr(1'b0);
      vectors++;
      if ({o_seq_done, o_ins_en} !== 2'b10) begin
         miscompares++;
         $display("FAIL loop_stop_same_cycle got done=%b en=%b expected 1/0", o_seq_done, o_ins_en);
      end
      step();
      chk_sb_empty("loop");
   endtask

   task automatic test_stop();
      r_frm_per_entry = 8'd2; r_seq_loop = 1'b0;
      seq_start();
      push_exp(0, 1'b1); pulse_vstr(1'b0);
      idle(2);
      r_seq_stop = 1'b1; step(); r_seq_stop = 1'b0;
      idle(3);
      vectors++;
      if ({o_ins_en, o_seq_busy, o_seq_done, o_entry_idx} !== {3'b110, 3'd0}) begin
         miscompares++;
         $display("FAIL stop_pending got en=%b busy=%b done=%b expected 1/1/0", o_ins_en, o_seq_busy, o_seq_done);
      end
      push_exp(0, 1'b0); pulse_vstr(1'b0);
      vectors++;
      if ({o_seq_done, o_ins_en} !== 2'b10) begin
         miscompares++;
         $display("FAIL stop_applied got done=%b en=%b expected 1/0", o_seq_done, o_ins_en);
      end
      step();
      chk_sb_empty("stop");
   endtask

   task automatic test_skip();
      wr_tbl(1, {1'b1, 10'h155, 8'd0, 8'd3});
      r_frm_per_entry = 8'd1;
      seq_start();
      push_exp(0, 1'b1); pulse_vstr(1'b0); idle(2);
      push_exp(1, 1'b0); pulse_vstr(1'b0);
      vectors++;
      if ({o_ent_skip, o_ins_en, o_entry_idx} !== {2'b10, 3'd1}) begin
         miscompares++;
         $display("FAIL skip_set got skip=%b en=%b idx=%0d expected 1/0/1", o_ent_skip, o_ins_en, o_entry_idx);
      end
      idle(2);
      push_exp(1, 1'b0); pulse_vstr(1'b0);
      vectors++;
      if ({o_seq_done, o_ent_skip} !== 2'b11) begin
         miscompares++;
         $display("FAIL skip_end got done=%b skip=%b expected 1/1", o_seq_done, o_ent_skip);
      end
      step();
      seq_start();
      vectors++;
      if ({o_ent_skip, o_seq_busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL skip_clear got skip=%b busy=%b expected 0/1", o_ent_skip, o_seq_busy);
      end
      r_seq_stop = 1'b1; step(); r_seq_stop = 1'b0;
      vectors++;
      if ({o_seq_done, o_seq_busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL arm_stop got done=%b busy=%b expected 1/0", o_seq_done, o_seq_busy);
      end
      step();
      r_num_entry = 4'd0; seq_start(); step();
      r_num_entry = 4'd2; r_seq_stop = 1'b1; seq_start(); r_seq_stop = 1'b0; step();
      vectors++;
      if (o_seq_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL start_ignored got busy=%b expected=0", o_seq_busy);
      end
      chk_sb_empty("skip");
   endtask

   task automatic test_saturate();
      r_num_entry = 4'd15; r_frm_per_entry = 8'd1; r_seq_loop = 1'b0;
      seq_start();
      for (int i = 0; i < NE; i++) begin
         push_exp(i, (tbl_m[i][STW +: STW] != '0) && (tbl_m[i][0 +: STW] != '0));
         pulse_vstr(1'b0);
         idle(2);
      end
      vectors++;
      if ({o_entry_idx, o_seq_busy} !== {3'd7, 1'b1}) begin
         miscompares++;
         $display("FAIL sat_last got idx=%0d busy=%b expected 7/1", o_entry_idx, o_seq_busy);
      end
      push_exp(NE - 1, 1'b0); pulse_vstr(1'b0);
      vectors++;
      if (o_seq_done !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_done got=%b expected=1", o_seq_done);
      end
      step();
      chk_sb_empty("sat");
   endtask

   task automatic test_async_reset();
      wr_tbl(1, {1'b1, 10'h000, 8'd8, 8'd2});
      r_num_entry = 4'd2; r_frm_per_entry = 8'd2;
      seq_start();
      push_exp(0, 1'b1); pulse_vstr(1'b0);
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_ins_en, o_seq_busy, o_entry_idx, o_hstep} !== '0) begin
         miscompares++;
         $display("FAIL async_rst got en=%b busy=%b idx=%0d expected 0", o_ins_en, o_seq_busy, o_entry_idx);
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < NE; i++) tbl_m[i] = '0;
      step();
      wr_tbl(0, {1'b1, 10'h2A5, 8'd3, 8'd5});
      seq_start();
      push_exp(0, 1'b1); pulse_vstr(1'b0);
      vectors++;
      if ({o_ins_en, o_entry_idx, o_clr_chg} !== {1'b1, 3'd0, 10'h2A5}) begin
         miscompares++;
         $display("FAIL restart got en=%b idx=%0d clr=%h expected 1/0/2a5", o_ins_en, o_entry_idx, o_clr_chg);
      end
      idle(2);
      chk_sb_empty("rst");
   endtask

   initial begin
      rst_n = 1'b0; i_vstr = 1'b0; i_hstr = 1'b0; r_tbl_wr = 1'b0;
      r_tbl_addr = '0; r_tbl_wdata = '0; r_num_entry = '0; r_frm_per_entry = '0;
      r_seq_loop = 1'b0; r_seq_start = 1'b0; r_seq_stop = 1'b0;
      for (int i = 0; i < NE; i++) tbl_m[i] = '0;
      test_reset();
      test_seq_once();
      test_loop();
      test_stop();
      test_skip();
      test_saturate();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
